serial_adder: RTL and testbench

Multi-cycle, parametrised adder/subtractor that generalises the single-bit full adder into a WIDTH-bit operation. It processes SLICE bits per clock through a ripple slice and a registered carry. It has a start/busy/done handshake and an add/subtract mode. It is the arithmetic building block for the datapath where area matters more than single-cycle latency.

---
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor. Processes SLICE bits
//                per clock through a ripple slice with a registered carry.
//                Uses a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  // Refuse to elaborate a slicing that leaves a partial slice at the top.
  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive integer multiple of SLICE");
  end

  localparam int C_N     = WIDTH / SLICE;
  localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;        // already inverted for subtract
  logic               carry_q, carry_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;    // partial result, filled from the MSB side
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SLICE-1:0]       w_slice_sum;
  logic                   w_c_slice;   // carry out of the current slice
  logic                   w_c_msb;     // carry into the top bit of the current slice
  logic [WIDTH+SLICE-1:0] w_res_cat;
  logic [WIDTH-1:0]       w_res_next;

  // Ripple adder over the low SLICE bits of the operand shift registers.
  always_comb begin : slice_adder
    logic v_c;
    v_c         = carry_q;
    w_c_msb     = carry_q;
    w_slice_sum = '0;
    for (int i = 0; i < SLICE; i++) begin
      w_c_msb        = v_c;
      w_slice_sum[i] = a_q[i] ^ b_q[i] ^ v_c;
      v_c            = (a_q[i] & b_q[i]) | (v_c & (a_q[i] ^ b_q[i]));
    end
    w_c_slice = v_c;
  end

  // New slice enters at the MSB end while older slices move toward bit 0.
  assign w_res_cat  = {w_slice_sum, res_q};
  assign w_res_next = w_res_cat[WIDTH+SLICE-1:SLICE];

  // Next-state and datapath control; outputs only change on the final slice.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = c_in ^ sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = w_c_slice;
        res_d   = w_res_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          sum_d   = w_res_next;
          c_out_d = w_c_slice;
          ovf_d   = w_c_msb ^ w_c_slice;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (8/1 and 4/2 variants).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8), .SLICE(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(4), .SLICE(2)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .c_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  exp_t sb8[$];
  exp_t sb4[$];
  exp_t last8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Independent signed/unsigned reference for the 4-bit instance.
  function automatic exp_t model4(input logic [3:0] ma, input logic [3:0] mb,
                                  input logic mc, input logic ms);
    exp_t e;
    int ua, ub, uc, sa, sb, r, rs;
    ua = int'(ma);
    ub = int'(mb);
    uc = int'(mc);
    sa = ma[3] ? ua - 16 : ua;
    sb = mb[3] ? ub - 16 : ub;
    if (!ms) begin
      r   = ua + ub + uc;
      rs  = sa + sb + uc;
      e.c = (r > 15);
    end else begin
      r   = ua - ub - uc;
      rs  = sa - sb - uc;
      e.c = (ua >= ub + uc);
    end
    e.s = 8'(r & 15);
    e.o = (rs > 7) || (rs < -8);
    return e;
  endfunction

  // Scoreboard pop/compare for the 8-bit instance.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut8_unexpected_done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = sb8.pop_front();
        chk("dut8_sum", 32'(sum8), 32'(e.s));
        chk("dut8_c_out", 32'(cout8), 32'(e.c));
        chk("dut8_overflow", 32'(ovf8), 32'(e.o));
      end
    end
  end

  // Scoreboard pop/compare for the 4-bit instance.
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (sb4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut4_unexpected_done: got done=1, expected no done");
      end else begin
        exp_t e;
        e = sb4.pop_front();
        chk("dut4_sum", 32'(sum4), 32'(e.s[3:0]));
        chk("dut4_c_out", 32'(cout4), 32'(e.c));
        chk("dut4_overflow", 32'(ovf4), 32'(e.o));
      end
    end
  end

  // Issue one 8-bit operation from a negedge; returns at the done negedge.
  // poke >= 0 pulses start with other operands in that RUN cycle.
  task automatic op8(input vec_t v, input int poke);
    exp_t e, prev;
    int   lat;
    logic bad_busy, bad_hold;
    e.s = v.s; e.c = v.c; e.o = v.o;
    a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
    @(posedge clk);
    sb8.push_back(e);
    prev  = last8;
    last8 = e;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    lat = 0; bad_busy = 1'b0; bad_hold = 1'b0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 !== 1'b1) bad_busy = 1'b1;
      if (sum8 !== prev.s || cout8 !== prev.c || ovf8 !== prev.o) bad_hold = 1'b1;
      if (lat == poke) begin
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    chk("dut8_latency", 32'(lat), 32'd8);
    chk("dut8_busy_during_run", 32'(bad_busy), 32'd0);
    chk("dut8_hold_during_run", 32'(bad_hold), 32'd0);
    chk("dut8_busy_in_done_cycle", 32'(busy8), 32'd0);
  endtask

  vec_t tbl [8];

  initial begin
    logic bad_lat4, bad_busy4;
    int   lat;
    vec_t v;

    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[4] = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    last8 = '{8'h00, 1'b0, 1'b0};

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_c_out8", 32'(cout8), 32'd0);
    chk("rst_overflow8", 32'(ovf8), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);

    // Table of 8-bit vectors, issued back-to-back from each done cycle.
    for (int i = 0; i < 8; i++) begin
      op8(tbl[i], -1);
    end

    // start pulsed with other operands in the 3rd RUN cycle is ignored.
    v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    op8(v, 2);
    repeat (12) @(negedge clk);
    chk("dut8_idle_after_ignored_start", 32'(busy8), 32'd0);

    // Reset in RUN cycle 4 aborts the operation with no done.
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("dut8_busy_before_abort", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy8", 32'(busy8), 32'd0);
    chk("abort_done8", 32'(done8), 32'd0);
    chk("abort_sum8", 32'(sum8), 32'd0);
    chk("abort_c_out8", 32'(cout8), 32'd0);
    chk("abort_overflow8", 32'(ovf8), 32'd0);
    last8 = '{8'h00, 1'b0, 1'b0};
    repeat (12) @(negedge clk);
    chk("dut8_idle_after_abort", 32'(busy8), 32'd0);

    // Reset coincident with start wins.
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
    @(negedge clk);
    start8 = 1'b0; rst = 1'b0;
    chk("rst_beats_start_busy8", 32'(busy8), 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_beats_start_still_idle8", 32'(busy8), 32'd0);

    // Re-issue after abort completes normally.
    v = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
    op8(v, -1);
    v = '{8'hC8, 8'h64, 1'b1, 1'b1, 8'h63, 1'b1, 1'b1};
    op8(v, -1);

    // Exhaustive 4-bit/2-slice sweep, back-to-back from each done cycle.
    bad_lat4 = 1'b0; bad_busy4 = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); sub4 = 1'(i >> 9);
      start4 = 1'b1;
      @(posedge clk);
      sb4.push_back(model4(a4, b4, cin4, sub4));
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      lat = 0;
      while (done4 !== 1'b1 && lat < 10) begin
        if (busy4 !== 1'b1) bad_busy4 = 1'b1;
        @(negedge clk);
        lat++;
      end
      if (lat != 2) bad_lat4 = 1'b1;
      if (busy4 !== 1'b0) bad_busy4 = 1'b1;
    end
    chk("dut4_latency_all", 32'(bad_lat4), 32'd0);
    chk("dut4_busy_all", 32'(bad_busy4), 32'd0);

    repeat (5) @(negedge clk);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb4_drained", 32'(sb4.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
